// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment scan driver with BCD/hex glyphs,
// per-digit blanking, leading-zero suppression and frame-aligned value update.
module sseg_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int CLK_DIV  = 50000,
  parameter int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  input  logic [N_DIGITS-1:0]     blank_mask,
  output logic [0:6]              sseg,
  output logic [N_DIGITS-1:0]     an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_sync
);

  localparam int               PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int               VW         = 4 * N_DIGITS;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]       SEG_DARK   = 7'b1111111;
  localparam logic [6:0]       SEG_DASH   = 7'b1111110;

  logic [PW-1:0]       presc;
  logic [IDX_W-1:0]    idx;
  logic                tick;
  logic                wrap;
  logic [VW-1:0]       shadow;
  logic [VW-1:0]       disp;
  logic                pending;
  logic [N_DIGITS-1:0] zero_from;
  logic                run;
  logic [3:0]          nib;
  logic [N_DIGITS-1:0] an_next;
  logic                sel_blank;
  logic                sel_zero;
  logic                dark;

  assign tick      = (presc == PRESC_LAST);
  assign wrap      = tick && (idx == IDX_LAST);
  assign digit_idx = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= wrap;
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
    end
  end

  // A load landing on the wrap edge bypasses the shadow so it is not deferred a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else if (load && wrap) begin
      shadow  <= value;
      disp    <= value;
      pending <= 1'b0;
    end else begin
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
      if (wrap && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end
    end
  end

  // zero_from[k]: nibbles k..N_DIGITS-1 of the displayed value are all zero.
  always_comb begin
    run       = 1'b1;
    zero_from = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run          = run && (disp[4*k +: 4] == 4'd0);
      zero_from[k] = run;
    end
  end

  always_comb begin
    nib       = '0;
    an_next   = '1;
    sel_blank = 1'b0;
    sel_zero  = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib        = disp[4*k +: 4];
        an_next[k] = 1'b0;
        sel_blank  = blank_mask[k];
        sel_zero   = (k != 0) && zero_from[k];
      end
    end
    dark = sel_blank || (lz_blank && sel_zero);
  end

  function automatic logic [6:0] glyph_of(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (!hex && (n > 4'd9)) begin
      g = SEG_DASH;
    end
    return g;
  endfunction

  // Dark digits keep their anode slot so every digit gets the same duty cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an   <= '1;
      sseg <= SEG_DARK;
    end else begin
      an   <= an_next;
      sseg <= dark ? SEG_DARK : glyph_of(nib, hex_mode);
    end
  end

endmodule
